// File: rtl/mult_io_pkg.sv
// Shared definitions for the IO multiplier sequencer: FSM encoding,
// iteration count and the IO register bit indices.
// NRV_MULT_RADIX4_EN selects the radix-4 datapath (16 steps) instead of the
// default radix-2 datapath (32 steps).
package mult_io_pkg;

  // Sequencer states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mult_state_t;

`ifdef NRV_MULT_RADIX4_EN
  localparam int MULT_STEPS      = 16;
  localparam int MULT_RADIX_BITS = 2;
`else
  localparam int MULT_STEPS      = 32;
  localparam int MULT_RADIX_BITS = 1;
`endif

  // Step counter only has to reach MULT_STEPS-1
  localparam int MULT_CNT_W = $clog2(MULT_STEPS);

  // IO register bit indices. The hardware configuration device mask uses the
  // same positions, so keep these in step with it.
  localparam int IO_MULT_A_BIT         = 0;
  localparam int IO_MULT_B_BIT         = 1;
  localparam int IO_MULT_RESULT_BIT    = 2;
  localparam int IO_MULT_RESULT_HI_BIT = 3;
  localparam int IO_MULT_REG_COUNT     = 4;

endpackage

// File: rtl/mult_io_step.sv
// Combinational single iteration of the shift-add multiplier.
// NRV_MULT_RADIX4_EN: consume two multiplier bits per step using the
// precomputed 3*mcand; otherwise one bit per step and mcand3 is ignored.
module mult_io_step
  import mult_io_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [2*WIDTH-1:0] mcand3,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] prod_next,
  output logic [2*WIDTH-1:0] mcand_next,
  output logic [WIDTH-1:0]   mplier_next
);

  logic [2*WIDTH-1:0] addend;

`ifdef NRV_MULT_RADIX4_EN
  // Pick 0, 1x, 2x or 3x multiplicand from the low two multiplier bits
  always_comb begin
    addend = '0;
    case (mplier[1:0])
      2'd1:    addend = mcand;
      2'd2:    addend = mcand << 1;
      2'd3:    addend = mcand3;
      default: addend = '0;
    endcase
  end
`else
  // The radix-2 datapath has no use for the 3x multiplicand
  logic unused_mcand3;
  assign unused_mcand3 = ^mcand3;
  assign addend = mplier[0] ? mcand : '0;
`endif

  // Carry out of the top bit is dropped; the final product always fits
  assign prod_next   = prod + addend;
  assign mcand_next  = mcand << MULT_RADIX_BITS;
  assign mplier_next = mplier >> MULT_RADIX_BITS;

endmodule

// File: rtl/mult_io_ctrl.sv
// Memory-mapped sequencer for the iterative unsigned multiplier behind the
// IO registers A, B, result low and result high. Writing B launches a
// multiply; result reads during a multiply are stalled via rbusy.
// NRV_MULT_RADIX4_EN: radix-4 iteration with a 3*mcand register (16 steps).
module mult_io_ctrl
  import mult_io_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wstrb,
  input  logic             sel_a,
  input  logic             sel_b,
  input  logic             sel_lo,
  input  logic             sel_hi,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             rbusy,
  output logic             busy
);

  mult_state_t state_reg, state_next;

  logic [WIDTH-1:0]      opa_reg, opa_next;
  logic [WIDTH-1:0]      mplier_reg, mplier_next;
  logic [2*WIDTH-1:0]    mcand_reg, mcand_next;
  logic [2*WIDTH-1:0]    prod_reg, prod_next;
  logic [MULT_CNT_W-1:0] cnt_reg, cnt_next;

  logic [2*WIDTH-1:0] prod_step, mcand_step;
  logic [WIDTH-1:0]   mplier_step;
  logic [2*WIDTH-1:0] mcand3_val;
  logic [2*WIDTH-1:0] opa_ext;

  logic [IO_MULT_REG_COUNT-1:0] sel_vec;
  logic                         wr_a, wr_b, last_step;

  // Gather the per-register selects into one vector in IO bit order
  assign sel_vec[IO_MULT_A_BIT]         = sel_a;
  assign sel_vec[IO_MULT_B_BIT]         = sel_b;
  assign sel_vec[IO_MULT_RESULT_BIT]    = sel_lo;
  assign sel_vec[IO_MULT_RESULT_HI_BIT] = sel_hi;

  // If A and B are both written at once, B wins and launches with the old A
  assign wr_b      = wstrb & sel_vec[IO_MULT_B_BIT];
  assign wr_a      = wstrb & sel_vec[IO_MULT_A_BIT] & ~sel_vec[IO_MULT_B_BIT];
  assign last_step = (cnt_reg == MULT_CNT_W'(MULT_STEPS - 1));
  assign opa_ext   = {{WIDTH{1'b0}}, opa_reg};

`ifdef NRV_MULT_RADIX4_EN
  logic [2*WIDTH-1:0] mcand3_reg, mcand3_next;

  // 3x multiplicand: loaded on launch, shifted alongside mcand
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand3_reg <= '0;
    end else begin
      mcand3_reg <= mcand3_next;
    end
  end

  // Next 3x multiplicand value
  always_comb begin
    mcand3_next = mcand3_reg;
    if (wr_b) begin
      mcand3_next = (opa_ext << 1) + opa_ext;
    end else if (state_reg == RUN) begin
      mcand3_next = mcand3_reg << MULT_RADIX_BITS;
    end
  end

  assign mcand3_val = mcand3_reg;
`else
  assign mcand3_val = '0;
`endif

  mult_io_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .prod       (prod_reg),
    .mcand      (mcand_reg),
    .mcand3     (mcand3_val),
    .mplier     (mplier_reg),
    .prod_next  (prod_step),
    .mcand_next (mcand_step),
    .mplier_next(mplier_step)
  );

  // State, datapath and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      opa_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      prod_reg   <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      opa_reg    <= opa_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      prod_reg   <= prod_next;
      cnt_reg    <= cnt_next;
    end
  end

  // Next-state, datapath update and status outputs
  always_comb begin
    state_next  = state_reg;
    opa_next    = opa_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    prod_next   = prod_reg;
    cnt_next    = cnt_reg;
    busy        = (state_reg == RUN);
    rbusy       = (state_reg == RUN) & (sel_lo | sel_hi) & ~wstrb;

    // A only touches the shadow; a running product keeps its launch operand
    if (wr_a) begin
      opa_next = wdata;
    end

    // B launches from IDLE and restarts from RUN, discarding any partial product
    if (wr_b) begin
      mcand_next  = opa_ext;
      mplier_next = wdata;
      prod_next   = '0;
      cnt_next    = '0;
      state_next  = RUN;
    end else if (state_reg == RUN) begin
      prod_next   = prod_step;
      mcand_next  = mcand_step;
      mplier_next = mplier_step;
      cnt_next    = cnt_reg + MULT_CNT_W'(1);
      if (last_step) begin
        state_next = IDLE;
      end
    end
  end

  // Result halves are readable; operand registers read back as zero
  assign rdata = sel_lo ? prod_reg[WIDTH-1:0] :
                 sel_hi ? prod_reg[2*WIDTH-1:WIDTH] : '0;

endmodule
